// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect/stall
// inputs from later stages, and the decoded head-instruction outputs.
//   master : the fetch unit (drives imem_req/addr and the head outputs)
//   slave  : the surrounding pipeline + instruction ROM
interface fetch_if #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               jump_taken;
    logic [ADDR_W-1:0]  jump_target;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_out;
    logic [1:0]         instruction_type;
    logic [1:0]         func;
    logic               imm;
    logic               vector;
    logic               halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  stall, jump_taken, jump_target,
        output instr_valid, instr, pc_out, instruction_type, func, imm, vector, halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output stall, jump_taken, jump_target,
        input  instr_valid, instr, pc_out, instruction_type, func, imm, vector, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Keeps the PC, reads a 1-cycle-latency synchronous ROM and buffers the
// returned words in a 2-entry prefetch FIFO. The FIFO head is presented
// with its decoded fields.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fetch_if.master (imem read port, stall/redirect, head outputs)
module fetch_unit #(
    parameter int INSTR_W  = 32,
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0,
    parameter int PC_INC   = 1
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pc, r_req_addr;
    logic               r_inflight;
    logic [1:0]         r_cnt;
    logic [INSTR_W-1:0] r_data0, r_data1;  // entry 0 is the head
    logic [ADDR_W-1:0]  r_addr0, r_addr1;

    logic               w_valid, w_pop, w_run, w_redirect, w_push, w_halt_pop, w_req;
    logic [2:0]         w_credit;
    logic [ADDR_W-1:0]  w_addr;
    logic [1:0]         w_n_cnt;
    logic [INSTR_W-1:0] w_n_d0, w_n_d1, w_instr;
    logic [ADDR_W-1:0]  w_n_a0, w_n_a1;

    assign w_valid    = (r_cnt != 2'd0);
    assign w_pop      = w_valid & ~bus.stall;
    assign w_run      = (r_state == S_RUN);
    assign w_redirect = w_run & bus.jump_taken;
    // Response is dropped on a redirect; in HALT nothing is accepted.
    assign w_push     = w_run & r_inflight & ~bus.jump_taken;
    assign w_halt_pop = w_run & ~bus.jump_taken & w_pop &
                        (r_data0[INSTR_W-1 -: 2] == 2'b11);

    // Credit: queued + outstanding after this cycle's pop must leave a slot.
    // pop implies r_cnt>=1, so this never underflows.
    assign w_credit = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_req    = w_redirect | (w_run & (w_credit < 3'd2));
    assign w_addr   = w_redirect ? bus.jump_target : r_pc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   if (w_halt_pop) w_state_nxt = S_HALT;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // FIFO next state: pop shifts entry 1 into the head, then the push
    // lands in the first free slot. Redirect/halt flush overrides both.
    always_comb begin
        w_n_d0  = r_data0;
        w_n_a0  = r_addr0;
        w_n_d1  = r_data1;
        w_n_a1  = r_addr1;
        w_n_cnt = r_cnt;
        if (w_pop) begin
            w_n_d0  = r_data1;
            w_n_a0  = r_addr1;
            w_n_cnt = r_cnt - 2'd1;
        end
        if (w_push) begin
            if (w_n_cnt == 2'd0) begin
                w_n_d0 = bus.imem_rdata;
                w_n_a0 = r_req_addr;
            end else begin
                w_n_d1 = bus.imem_rdata;
                w_n_a1 = r_req_addr;
            end
            w_n_cnt = w_n_cnt + 2'd1;
        end
        if (w_redirect || w_halt_pop) w_n_cnt = 2'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_BOOT;
            r_pc       <= ADDR_W'(RESET_PC);
            r_req_addr <= '0;
            r_inflight <= 1'b0;
            r_cnt      <= 2'd0;
            r_data0    <= '0;
            r_data1    <= '0;
            r_addr0    <= '0;
            r_addr1    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_req;
            r_cnt      <= w_n_cnt;
            r_data0    <= w_n_d0;
            r_data1    <= w_n_d1;
            r_addr0    <= w_n_a0;
            r_addr1    <= w_n_a1;
            if (w_req) begin
                r_pc       <= w_addr + ADDR_W'(PC_INC);
                r_req_addr <= w_addr;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && !w_pop && r_cnt == 2'd2));

    // Head outputs are zero whenever the FIFO is empty.
    assign w_instr              = w_valid ? r_data0 : '0;
    assign bus.imem_req         = w_req;
    assign bus.imem_addr        = w_addr;
    assign bus.instr_valid      = w_valid;
    assign bus.instr            = w_instr;
    assign bus.pc_out           = w_valid ? r_addr0 : '0;
    assign bus.instruction_type = w_instr[INSTR_W-1 -: 2];
    assign bus.func             = w_instr[INSTR_W-3 -: 2];
    assign bus.imm              = w_instr[INSTR_W-5];
    assign bus.vector           = w_instr[INSTR_W-6];
    assign bus.halted           = (r_state == S_HALT);
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    logic halt_en;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fetch_if #(.INSTR_W(32), .ADDR_W(16)) bus();

    fetch_unit #(.INSTR_W(32), .ADDR_W(16), .RESET_PC(0), .PC_INC(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM[i] = i+0x100, except word 3 (type 01, func 10, imm 1) and,
    // when halt_en, word 5 (type 11, func 01, vector 1).
    function automatic logic [31:0] rom(input logic [15:0] a);
        if (a == 16'd3) return 32'h6800_0103;
        if (halt_en && a == 16'd5) return 32'hD400_0105;
        return 32'h100 + {16'h0, a};
    endfunction

    always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= rom(bus.imem_addr);

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [15:0] pc);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_pc"}, 32'(bus.pc_out), 32'(pc));
        chk({tag, "_instr"}, bus.instr, rom(pc));
    endtask

    initial begin
        rst = 1'b0; halt_en = 1'b0;
        bus.stall = 1'b0; bus.jump_taken = 1'b0; bus.jump_target = '0;
        bus.imem_rdata = '0;
        tick(); tick();
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc", 32'(bus.pc_out), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_type", 32'(bus.instruction_type), 32'd0);

        // Latency and throughput
        rst = 1'b1;
        tick();
        chk("boot_valid", 32'(bus.instr_valid), 32'd0);
        chk("run_req", 32'(bus.imem_req), 32'd1);
        chk("run_addr", 32'(bus.imem_addr), 32'd0);
        tick();
        chk("e2_valid", 32'(bus.instr_valid), 32'd0);
        tick(); chk_head("lat0", 16'd0);
        tick(); chk_head("seq1", 16'd1);
        tick(); chk_head("seq2", 16'd2);

        // Stall held 4 cycles
        bus.stall = 1'b1; #1;
        chk("stall_req0", 32'(bus.imem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_head("stall_hold", 16'd2);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
        end
        bus.stall = 1'b0; #1;
        chk("rel_req", 32'(bus.imem_req), 32'd1);
        chk("rel_addr", 32'(bus.imem_addr), 32'd4);
        for (int k = 3; k <= 5; k++) begin
            tick(); chk_head("rel_seq", 16'(k));
            if (k == 3) begin
                chk("f3_type", 32'(bus.instruction_type), 32'd1);
                chk("f3_func", 32'(bus.func), 32'd2);
                chk("f3_imm", 32'(bus.imm), 32'd1);
                chk("f3_vec", 32'(bus.vector), 32'd0);
            end
        end

        // Redirect from streaming state
        bus.jump_taken = 1'b1; bus.jump_target = 16'h40; #1;
        chk("jmp_req", 32'(bus.imem_req), 32'd1);
        chk("jmp_addr", 32'(bus.imem_addr), 32'h40);
        tick(); bus.jump_taken = 1'b0;
        chk("jmp_bubble", 32'(bus.instr_valid), 32'd0);
        chk("jmp_bubble_instr", bus.instr, 32'd0);
        tick(); chk_head("jmp_t0", 16'h40);
        tick(); chk_head("jmp_t1", 16'h41);

        // Redirect while stalled with a full FIFO
        bus.stall = 1'b1;
        tick(); chk_head("js_hold", 16'h41);
        chk("js_full_req", 32'(bus.imem_req), 32'd0);
        bus.jump_taken = 1'b1; bus.jump_target = 16'h80; #1;
        chk("js_req", 32'(bus.imem_req), 32'd1);
        chk("js_addr", 32'(bus.imem_addr), 32'h80);
        tick(); bus.jump_taken = 1'b0; bus.stall = 1'b0;
        chk("js_bubble", 32'(bus.instr_valid), 32'd0);
        tick(); chk_head("js_t0", 16'h80);
        tick(); chk_head("js_t1", 16'h81);

        // Reset mid-stream with FIFO full
        bus.stall = 1'b1;
        tick(); chk_head("pre_rst", 16'h81);
        #1 rst = 1'b0; #1;
        chk("mrst_valid", 32'(bus.instr_valid), 32'd0);
        chk("mrst_instr", bus.instr, 32'd0);
        chk("mrst_pc", 32'(bus.pc_out), 32'd0);
        chk("mrst_req", 32'(bus.imem_req), 32'd0);
        bus.stall = 1'b0; halt_en = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        chk("rr_e2_valid", 32'(bus.instr_valid), 32'd0);
        tick(); chk_head("rr_pc0", 16'd0);
        for (int k = 1; k <= 5; k++) begin
            tick(); chk_head("rr_seq", 16'(k));
        end
        chk("h_type", 32'(bus.instruction_type), 32'd3);
        chk("h_func", 32'(bus.func), 32'd1);
        chk("h_imm", 32'(bus.imm), 32'd0);
        chk("h_vec", 32'(bus.vector), 32'd1);
        chk("h_pre_halted", 32'(bus.halted), 32'd0);

        // Halt after popping the type-11 word; redirect ignored
        tick();
        chk("halted", 32'(bus.halted), 32'd1);
        chk("halt_valid", 32'(bus.instr_valid), 32'd0);
        chk("halt_req", 32'(bus.imem_req), 32'd0);
        bus.jump_taken = 1'b1; bus.jump_target = 16'h40; #1;
        chk("halt_jmp_req", 32'(bus.imem_req), 32'd0);
        tick(); bus.jump_taken = 1'b0;
        chk("halt_jmp_halted", 32'(bus.halted), 32'd1);
        chk("halt_jmp_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("halt_stay_valid", 32'(bus.instr_valid), 32'd0);
        chk("halt_stay_req", 32'(bus.imem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
